// File: rtl/seq_match_pkg.sv
// Shared definitions for the serial pattern-match controller.
//   state_e      : controller state (idle, armed, done)
//   DEF_*        : default widths for the controller and its interface
//   len_legal()  : true when a requested pattern length is within 1..maxlen
package seq_match_pkg;

    localparam int unsigned DEF_MAXLEN = 8;
    localparam int unsigned DEF_LENW   = 4;
    localparam int unsigned DEF_CNTW   = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic logic len_legal(input int unsigned len, input int unsigned maxlen);
        return (len != 0) && (len <= maxlen);
    endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Handshake/bus bundle for seq_match_ctrl.
//   cfg_*      : configuration load (pattern, length, overlap mode, target count)
//   arm/disarm : start / abort matching
//   bit_valid/bit_in : qualified serial stream
//   match, match_count, armed, done, cfg_err : status back from the controller
// master drives configuration and stream; slave is the controller.
interface seq_match_ctrl_if
    import seq_match_pkg::*;
#(
    parameter int unsigned MAXLEN = DEF_MAXLEN,
    parameter int unsigned LENW   = DEF_LENW,
    parameter int unsigned CNTW   = DEF_CNTW
) ();

    logic              cfg_we;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic              cfg_overlap;
    logic [CNTW-1:0]   cfg_target;
    logic              arm;
    logic              disarm;
    logic              bit_valid;
    logic              bit_in;
    logic              match;
    logic [CNTW-1:0]   match_count;
    logic              armed;
    logic              done;
    logic              cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output arm, disarm, bit_valid, bit_in,
        input  match, match_count, armed, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  arm, disarm, bit_valid, bit_in,
        output match, match_count, armed, done, cfg_err
    );

endinterface

// File: rtl/seq_match_window.sv
// Sliding bit window for the pattern matcher.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : empty the window (arming)
//   shift    : accept bit_in into the window this cycle
//   flush    : together with shift, empty the window instead (non-overlap match)
//   bit_in   : incoming serial bit
//   pattern  : pattern, bit [len-1] first received
//   len      : active pattern length, 1..MAXLEN
//   hit      : window plus bit_in matches the low len pattern bits (unqualified)
module seq_match_window #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned LENW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic              flush,
    input  logic              bit_in,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LENW-1:0]   len,
    output logic              hit
);

    // Only MAXLEN-1 history bits are kept: the oldest bit of a MAXLEN-bit
    // history would shift out before it could ever be compared.
    logic [MAXLEN-2:0] hist_q;
    logic [LENW-1:0]   fill_q;
    logic [MAXLEN-1:0] window;
    logic [MAXLEN-1:0] mask;

    assign window = {hist_q, bit_in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (LENW'(i) < len);
        end
    end

    assign hit = (fill_q >= (len - LENW'(1))) && (((window ^ pattern) & mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            if (flush) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= window[MAXLEN-2:0];
                if (fill_q != LENW'(MAXLEN)) begin
                    fill_q <= fill_q + LENW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern-match controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_match_ctrl_if.slave -- configuration load, arm/disarm,
//              serial stream in; match (combinational), match_count, armed,
//              done, cfg_err (registered) out.
// Config is accepted only while not armed; an illegal or mistimed load leaves
// the config untouched and pulses cfg_err for one cycle.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int unsigned MAXLEN = DEF_MAXLEN,
    parameter int unsigned LENW   = DEF_LENW,
    parameter int unsigned CNTW   = DEF_CNTW
) (
    input logic             clk,
    input logic             rst,
    seq_match_ctrl_if.slave bus
);

    state_e            state_q;
    logic [MAXLEN-1:0] pattern_q;
    logic [LENW-1:0]   len_q;
    logic              overlap_q;
    logic [CNTW-1:0]   target_q;
    logic [CNTW-1:0]   count_q;
    logic              armed_q;
    logic              done_q;
    logic              cfg_err_q;

    logic              hit;
    logic              match;
    logic              arm_go;
    logic              cfg_ok;
    logic              reach;
    logic [CNTW-1:0]   count_inc;

    // Disarm wins over arm; arm only acts from idle or done.
    assign arm_go    = bus.arm & ~bus.disarm & ~armed_q;
    assign cfg_ok    = ~armed_q & len_legal(32'(bus.cfg_len), MAXLEN);
    assign match     = armed_q & bus.bit_valid & hit;
    assign count_inc = (&count_q) ? count_q : count_q + CNTW'(1);
    assign reach     = (target_q != '0) && (count_inc == target_q);

    seq_match_window #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .clear   (arm_go),
        .shift   (armed_q & bus.bit_valid),
        .flush   (match & ~overlap_q),
        .bit_in  (bus.bit_in),
        .pattern (pattern_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            len_q     <= LENW'(1);
            overlap_q <= 1'b0;
            target_q  <= '0;
            count_q   <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (bus.cfg_we) begin
                if (cfg_ok) begin
                    pattern_q <= bus.cfg_pattern;
                    len_q     <= bus.cfg_len;
                    overlap_q <= bus.cfg_overlap;
                    target_q  <= bus.cfg_target;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (arm_go) begin
                        state_q <= StArmed;
                        armed_q <= 1'b1;
                        count_q <= '0;
                    end
                end
                StArmed: begin
                    // A match on the disarm cycle still counts.
                    if (match) begin
                        count_q <= count_inc;
                    end
                    if (bus.disarm) begin
                        state_q <= StIdle;
                        armed_q <= 1'b0;
                    end else if (match && reach) begin
                        state_q <= StDone;
                        armed_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.disarm) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end else if (arm_go) begin
                        state_q <= StArmed;
                        armed_q <= 1'b1;
                        done_q  <= 1'b0;
                        count_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    armed_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.match       = match;
    assign bus.match_count = count_q;
    assign bus.armed       = armed_q;
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed, table-driven bench for seq_match_ctrl.
module tb_seq_match_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_match_ctrl_if #(.MAXLEN(8), .LENW(4), .CNTW(8)) bus ();

    seq_match_ctrl #(.MAXLEN(8), .LENW(4), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic [7:0] tgt;
        logic       arm;
        logic       dis;
        logic       bv;
        logic       bi;
        logic       em;   // match before the edge
        logic [7:0] ec;   // registered outputs after the edge
        logic       ea;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic [7:0] tgt, input logic arm,
                       input logic dis, input logic bv, input logic bi, input logic em,
                       input logic [7:0] ec, input logic ea, input logic ed, input logic ee);
        vec_t v;
        v.we = we; v.pat = pat; v.len = len; v.ovl = ovl; v.tgt = tgt;
        v.arm = arm; v.dis = dis; v.bv = bv; v.bi = bi;
        v.em = em; v.ec = ec; v.ea = ea; v.ed = ed; v.ee = ee;
        vecs.push_back(v);
    endtask

    // Shorthand: stream bit, with expected match and post-edge count/armed/done.
    task automatic bitv(input logic bi, input logic em, input logic [7:0] ec,
                        input logic ea, input logic ed);
        add(0, 8'h00, 4'd0, 0, 8'h00, 0, 0, 1, bi, em, ec, ea, ed, 0);
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        bus.cfg_we      = v.we;
        bus.cfg_pattern = v.pat;
        bus.cfg_len     = v.len;
        bus.cfg_overlap = v.ovl;
        bus.cfg_target  = v.tgt;
        bus.arm         = v.arm;
        bus.disarm      = v.dis;
        bus.bit_valid   = v.bv;
        bus.bit_in      = v.bi;
        #1;
        chk("match", idx, 32'(bus.match), 32'(v.em));
        @(posedge clk);
        #1;
        chk("match_count", idx, 32'(bus.match_count), 32'(v.ec));
        chk("armed", idx, 32'(bus.armed), 32'(v.ea));
        chk("done", idx, 32'(bus.done), 32'(v.ed));
        chk("cfg_err", idx, 32'(bus.cfg_err), 32'(v.ee));
    endtask

    task automatic run_all(input int base);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], base + i);
        end
        vecs.delete();
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus.cfg_target = '0; bus.arm = 0; bus.disarm = 0;
        // Reset pattern is 0/len 1, so a valid 0 would match if not gated by armed.
        bus.bit_valid = 1; bus.bit_in = 0;
        #2;
        chk("rst_match", 0, 32'(bus.match), 0);
        chk("rst_count", 0, 32'(bus.match_count), 0);
        chk("rst_armed", 0, 32'(bus.armed), 0);
        chk("rst_done", 0, 32'(bus.done), 0);
        chk("rst_cfg_err", 0, 32'(bus.cfg_err), 0);
        @(negedge clk);
        bus.bit_valid = 0;
        rst = 1'b0;

        // Overlap on: 1101 found at bits 4 and 7.
        add(1, 8'h0D, 4'd4, 1, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
        bitv(1, 1, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(0, 0, 1, 1, 0);
        bitv(1, 1, 2, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd2, 0, 0, 0);

        // Overlap off: only bit 4 matches.
        add(1, 8'h0D, 4'd4, 0, 8'd0, 0, 0, 0, 0, 0, 8'd2, 0, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
        bitv(1, 1, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(0, 0, 1, 1, 0);
        bitv(1, 0, 1, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0);

        // Target 2 on pattern 11: done after bit 3, then bits ignored; re-arm from done.
        add(1, 8'h03, 4'd2, 1, 8'd2, 0, 0, 0, 0, 0, 8'd1, 0, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 1, 1, 1, 0); bitv(1, 1, 2, 0, 1);
        bitv(1, 0, 2, 0, 1);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd0, 0, 0, 0);

        // Config rejects: load while armed, len 0, len MAXLEN+1; old config still matches.
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        add(1, 8'h00, 4'd2, 1, 8'd0, 0, 0, 0, 0, 0, 8'd0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 1, 1, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0);
        add(1, 8'h00, 4'd0, 1, 8'd0, 0, 0, 0, 0, 0, 8'd1, 0, 0, 1);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd1, 0, 0, 0);
        add(1, 8'h00, 4'd9, 1, 8'd0, 0, 0, 0, 0, 0, 8'd1, 0, 0, 1);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 1, 1, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0);

        // Arm+disarm together goes idle; idle bits ignored; re-arm clears history/count;
        // match on the disarm cycle still counts.
        add(1, 8'h0D, 4'd4, 1, 8'd0, 0, 0, 0, 0, 0, 8'd1, 0, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
        bitv(1, 1, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(0, 0, 1, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 1, 0, 0, 0, 8'd1, 0, 0, 0);
        bitv(1, 0, 1, 0, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 1, 1, 1, 8'd1, 0, 0, 0);

        // Lead-in for the reset case: armed with one match recorded, history 110110.
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
        bitv(1, 1, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(0, 0, 1, 1, 0);
        run_all(1);

        // Async reset mid-stream, while a matching bit is presented.
        @(negedge clk);
        bus.bit_valid = 1; bus.bit_in = 1;
        #1;
        chk("pre_rst_match", 900, 32'(bus.match), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_match", 901, 32'(bus.match), 0);
        chk("async_rst_count", 901, 32'(bus.match_count), 0);
        chk("async_rst_armed", 901, 32'(bus.armed), 0);
        chk("async_rst_done", 901, 32'(bus.done), 0);
        #1;
        rst = 1'b0;
        bus.bit_valid = 0;

        // Reset config is pattern 0, len 1: every valid 0 matches.
        add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(0, 1, 1, 1, 0); bitv(1, 0, 1, 1, 0); bitv(0, 1, 2, 1, 0);
        add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd2, 0, 0, 0);
        // Full pattern required after reset; cfg and arm in the same cycle.
        add(1, 8'h0D, 4'd4, 1, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0);
        bitv(1, 0, 0, 1, 0); bitv(1, 0, 0, 1, 0); bitv(0, 0, 0, 1, 0);
        bitv(1, 1, 1, 1, 0);
        run_all(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Programmable serial pattern-match controller for the lab's sequence-detection path. It holds a runtime-loaded pattern of up to MAXLEN bits, an overlap mode and a target match count. It arms and disarms matching on a qualified serial bit stream, raises a same-cycle (Mealy) match pulse, counts matches and signals completion. It sits between the input front-end (button/switch conditioning) and the display/LED logic, replacing hard-coded detector FSMs.

Parameters:
MAXLEN, 8, maximum pattern length in bits (>=2)
LENW, 4, width of cfg_len; must hold MAXLEN
CNTW, 8, width of match counter and target

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  load configuration this cycle
cfg_pattern  input  MAXLEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  input  LENW  pattern length, legal range 1..MAXLEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match
cfg_target  input  CNTW  matches needed for done; 0 = unlimited
arm  input  1  start matching
disarm  input  1  abort matching, return to IDLE
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial data bit
match  output  1  Mealy pulse: the current valid bit completes the pattern
match_count  output  CNTW  matches since arm, saturating
armed  output  1  state == ARMED
done  output  1  state == DONE
cfg_err  output  1  one-cycle registered pulse: config rejected

Behaviour:
- Reset (async): state IDLE; pattern 0, len 1, overlap 0, target 0; history 0; fill 0; match_count 0; cfg_err 0. match is 0 because armed is 0.
- States: IDLE, ARMED, DONE (shared enum).
- IDLE -> ARMED on arm. Arming clears history, fill and match_count.
- ARMED -> IDLE on disarm.
- ARMED -> DONE on the clock edge where a match makes count == target (target != 0).
- DONE -> IDLE on disarm. DONE -> ARMED on arm, which clears count and history.
- Simultaneous arm and disarm: disarm wins.
- Configuration:
  - cfg_we is accepted only in IDLE or DONE. Registers update on that clock edge.
  - cfg_we in ARMED, or cfg_len == 0, or cfg_len > MAXLEN: configuration unchanged; cfg_err = 1 next cycle.
  - cfg_we together with arm in the same cycle: config loads first, and arming uses the new config.
- History and fill:
  - History is a MAXLEN-bit shift register. On each bit_valid in ARMED: history <= {history[MAXLEN-2:0], bit_in}.
  - fill counts valid bits since arm or since the last non-overlap match, saturating at MAXLEN.
  - Bits are ignored outside ARMED and when bit_valid = 0.
- Match is combinational:
  - match = armed & bit_valid & (fill >= len-1) & ({history, bit_in} low len bits == pattern low len bits).
  - No registered delay.
- On match:
  - match_count increments, saturating at 2^CNTW-1.
  - If overlap = 0: fill <= 0 and history <= 0 on that edge.
  - If overlap = 1: history shifts normally.
- Mid-operation events:
  - disarm on the same cycle as a valid matching bit: match still pulses and the count increments, but the state goes to IDLE.
  - Async reset mid-stream discards all state.
- len = 1: every valid bit equal to pattern[0] matches.
- Outputs armed, done and match_count are registered (state decodes). Only match is combinational.

Decomposition:
- Package seq_match_pkg holds:
  - the state enum {IDLE, ARMED, DONE}
  - default MAXLEN/LENW/CNTW constants
  - the legal-length check function
- One natural sub-module: seq_match_window. It contains the history shift register, the fill counter and the masked compare, and produces the raw hit. The top level holds the FSM, the config registers and the counter.

Test Plan:
- Pattern 1101, len 4, overlap 1, target 0; arm; stream 1,1,0,1,1,0,1 -> match on the 4th and 7th bits; match_count = 2; state stays ARMED.
- Same stream with overlap 0 -> match on the 4th bit only; match_count = 1.
- Target 2, pattern 11, len 2, overlap 1; stream 1,1,1 -> matches on bits 2 and 3; done = 1 the cycle after bit 3; further bits produce no match.
- cfg_we while ARMED, and separately cfg_len = 0 or MAXLEN+1 in IDLE -> cfg_err pulses once; the pattern still matches the old config.
- Stream 1,1,0 then disarm with arm asserted in the same cycle -> IDLE; following bit 1 gives no match; re-arm clears count to 0.
- Assert rst asynchronously mid-pattern -> all outputs 0 immediately; after re-arm, a full pattern is required before match.
